scaler_v_ctrl: RTL and testbench
================================

# scaler_v_ctrl

Configuration sequencer for the vertical scaler datapath. It accepts a requested input height, output height and output line length, and computes the 4.12 fixed-point `scale_step` with an iterative restoring divider. It stages the result and commits it to the scaler's `scale_step`/`scale_line_size` inputs only on a frame boundary (falling edge of `vs_i`), so the scaler never sees a parameter change mid-frame. It sits between the register/host interface and the scaler instance in the video pipeline.

## Interface
- `LINE_STEP`, 4096: fixed-point 1.0 (4.12); numerator multiplier and reset value of `scale_step`.
- `LINE_SIZE_MAX`, 1024: largest legal `cfg_line_size`.
- `DEFAULT_LINE_SIZE`, 1024: line length in effect after reset.

Ports:
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  synchronous, active-low reset (0 = reset).
- `cfg_in_height`  in  16  source lines per frame.
- `cfg_out_height`  in  16  destination lines per frame.
- `cfg_line_size`  in  16  destination pixels per line (1..LINE_SIZE_MAX).
- `cfg_valid`  in  1  request valid.
- `cfg_ready`  out  1  block can accept a request.
- `vs_i`  in  1  frame sync, the same signal that drives the scaler's `vs_i`.
- `scale_step`  out  16  committed step, 4.12 unsigned.
- `scale_line_size`  out  16  committed value, equal to `cfg_line_size` - 1; the scaler emits `scale_line_size`+1 pixels.
- `cfg_err`  out  1  one-cycle pulse when a request is rejected.
- `cfg_sat`  out  1  sticky flag: the pending or committed step was clamped. Cleared by the next accepted request.
- `pending`  out  1  staged parameters are waiting for a frame boundary.
- `upd_o`  out  1  one-cycle pulse on the cycle after a commit.

## Operation
- **Handshake:** a request is accepted when `cfg_valid & cfg_ready`. `cfg_ready` = 1 only in IDLE, and does not depend on `pending`. Inputs are sampled only on the accept cycle.
- **Validation on the accept cycle:**
  - `cfg_out_height` == 0, `cfg_line_size` == 0, or `cfg_line_size` > LINE_SIZE_MAX → pulse `cfg_err` on the next cycle, stay in IDLE, leave staged and committed values untouched.
- **FSM:**
  - IDLE → DIV on a valid accept. Load the 28-bit numerator = `cfg_in_height` × LINE_STEP and the 16-bit divisor. Latch `cfg_line_size`-1. Clear `cfg_sat`.
  - DIV: restoring division, one quotient bit per cycle, MSB first, 28 cycles. 17-bit partial remainder; the quotient is truncated (floor).
  - DIV → DONE after the 28th iteration.
  - DONE: write the staged step and line size, set `pending`, → IDLE.
  - Quotient > 0xFFFF → staged step = 0xFFFF and `cfg_sat` = 1.
- **Commit:** a frame edge is `vs_i` = 0 in the current cycle with `vs_i` = 1 registered from the previous cycle.
  - On an edge with `pending` = 1: copy the staged values to the outputs, clear `pending`, pulse `upd_o` on the next cycle.
- **Boundary cases:**
  - A new request accepted while `pending` = 1: the old staged values stay valid until the new DONE overwrites them. A frame edge during DIV commits the old staged values.
  - DONE and a frame edge in the same cycle: the edge sees the old `pending`. If `pending` was 0, nothing commits and the new values wait for the next edge. If `pending` was 1, the old staged values commit, and the new values (written by DONE the same cycle) stay staged with `pending` = 1.
  - A frame edge with `pending` = 0: no action.
- **Reset (`rst` = 0):** state = IDLE, `scale_step` = LINE_STEP, `scale_line_size` = DEFAULT_LINE_SIZE-1, `cfg_ready` = 1 after release, `cfg_err` = 0, `cfg_sat` = 0, `pending` = 0, `upd_o` = 0, registered `vs_i` = 0. Reset during DIV abandons the division; staged values are discarded.

## Timing
- Accept at cycle 0 → DIV occupies cycles 1..28 → DONE at cycle 29 → `pending` = 1 and `cfg_ready` = 1 at cycle 30.
- `cfg_ready` = 0 during cycles 1..29.
- `cfg_err` is high at cycle 1 for a rejected request; `cfg_ready` stays 1.
- Commit: frame edge detected at cycle E → outputs change and `pending` = 0 at E+1 → `upd_o` = 1 during E+1 only.
- Committed outputs are registered and stable for the whole frame.

## Test plan
- Reset, then hold `rst` = 0 for 3 cycles → `scale_step` = 4096, `scale_line_size` = 1023, `cfg_ready` = 1, `pending` = 0.
- Request in 1080 / out 720 / line 640 → `pending` at cycle 30. The next `vs_i` falling edge gives `scale_step` = 6144 (0x1800), `scale_line_size` = 639, and a single `upd_o` pulse.
- Request in 720 / out 1080 / line 1024 → step 2730 (floor). With no `vs_i` edge, the outputs stay at their old values and `pending` = 1 indefinitely.
- Request out_h = 0, then line = 1025 → each gives a single `cfg_err` pulse at cycle 1; outputs and `pending` unchanged.
- Request in 65535 / out 1 → `cfg_sat` = 1 and staged step 0xFFFF, committed at the next edge. A following 1080/720 request clears `cfg_sat` at its accept cycle.
- A `vs_i` edge on the same cycle as DONE for a request made with `pending` = 0 → no commit at that edge; commit happens at the following edge. Also: `rst` = 0 mid-DIV → after release, `pending` = 0 and the outputs are at their reset values.

Source files
------------

// File: rtl/scaler_v_ctrl.sv
`default_nettype none
// ============================================================================
// scaler_v_ctrl : computes the 4.12 vertical scale step with a restoring
//                 divider and commits it to the scaler on a vs_i falling edge.
// Rev 1.0
// ============================================================================
module scaler_v_ctrl #(
  parameter int LINE_STEP         = 4096,
  parameter int LINE_SIZE_MAX     = 1024,
  parameter int DEFAULT_LINE_SIZE = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] cfg_in_height,
  input  logic [15:0] cfg_out_height,
  input  logic [15:0] cfg_line_size,
  input  logic        cfg_valid,
  output logic        cfg_ready,
  input  logic        vs_i,
  output logic [15:0] scale_step,
  output logic [15:0] scale_line_size,
  output logic        cfg_err,
  output logic        cfg_sat,
  output logic        pending,
  output logic        upd_o
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIV  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [15:0] C_STEP_RST = 16'(LINE_STEP);
  localparam logic [15:0] C_LINE_RST = 16'(DEFAULT_LINE_SIZE - 1);
  localparam logic [15:0] C_LINE_MAX = 16'(LINE_SIZE_MAX);
  localparam logic [27:0] C_NUM_MUL  = 28'(LINE_STEP);
  localparam logic [4:0]  C_LAST_IT  = 5'd27;

  state_t      state_q, state_d;
  logic [27:0] quo_q, quo_d;
  logic [15:0] rem_q, rem_d;
  logic [15:0] div_q, div_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [15:0] line_q, line_d;
  logic [15:0] stg_step_q, stg_step_d;
  logic [15:0] stg_line_q, stg_line_d;
  logic [15:0] step_q, step_d;
  logic [15:0] lsize_q, lsize_d;
  logic        err_q, err_d;
  logic        sat_q, sat_d;
  logic        pend_q, pend_d;
  logic        upd_q, upd_d;
  logic        vs_q;

  logic [16:0] w_trial;
  logic [15:0] w_diff;
  logic        w_ge;
  logic        w_ovf;
  logic        w_bad;
  logic        w_edge;

  // quo_q holds the numerator, then shifts quotient bits in from the LSB
  assign w_trial = {rem_q, quo_q[27]};
  assign w_ge    = (w_trial >= {1'b0, div_q});
  assign w_diff  = w_trial[15:0] - div_q;
  assign w_ovf   = |quo_q[27:16];
  assign w_bad   = (cfg_out_height == 16'd0) || (cfg_line_size == 16'd0) ||
                   (cfg_line_size > C_LINE_MAX);
  assign w_edge  = vs_q & ~vs_i;

  always_comb begin
    state_d    = state_q;
    quo_d      = quo_q;
    rem_d      = rem_q;
    div_d      = div_q;
    cnt_d      = cnt_q;
    line_d     = line_q;
    stg_step_d = stg_step_q;
    stg_line_d = stg_line_q;
    step_d     = step_q;
    lsize_d    = lsize_q;
    sat_d      = sat_q;
    pend_d     = pend_q;
    err_d      = 1'b0;
    upd_d      = 1'b0;

    // Commit is evaluated first so a same-cycle DONE can re-arm pending.
    if (w_edge && pend_q) begin
      step_d  = stg_step_q;
      lsize_d = stg_line_q;
      pend_d  = 1'b0;
      upd_d   = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (cfg_valid) begin
          if (w_bad) begin
            err_d = 1'b1;
          end else begin
            state_d = ST_DIV;
            quo_d   = 28'(cfg_in_height) * C_NUM_MUL;
            rem_d   = 16'd0;
            div_d   = cfg_out_height;
            cnt_d   = 5'd0;
            line_d  = cfg_line_size - 16'd1;
            sat_d   = 1'b0;
          end
        end
      end
      ST_DIV: begin
        quo_d = {quo_q[26:0], w_ge};
        rem_d = w_ge ? w_diff : w_trial[15:0];
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == C_LAST_IT) state_d = ST_DONE;
      end
      ST_DONE: begin
        stg_step_d = w_ovf ? 16'hFFFF : quo_q[15:0];
        stg_line_d = line_q;
        pend_d     = 1'b1;
        if (w_ovf) sat_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      quo_q      <= 28'd0;
      rem_q      <= 16'd0;
      div_q      <= 16'd0;
      cnt_q      <= 5'd0;
      line_q     <= C_LINE_RST;
      stg_step_q <= C_STEP_RST;
      stg_line_q <= C_LINE_RST;
      step_q     <= C_STEP_RST;
      lsize_q    <= C_LINE_RST;
      err_q      <= 1'b0;
      sat_q      <= 1'b0;
      pend_q     <= 1'b0;
      upd_q      <= 1'b0;
      vs_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      quo_q      <= quo_d;
      rem_q      <= rem_d;
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      line_q     <= line_d;
      stg_step_q <= stg_step_d;
      stg_line_q <= stg_line_d;
      step_q     <= step_d;
      lsize_q    <= lsize_d;
      err_q      <= err_d;
      sat_q      <= sat_d;
      pend_q     <= pend_d;
      upd_q      <= upd_d;
      vs_q       <= vs_i;
    end
  end

  assign cfg_ready       = (state_q == ST_IDLE);
  assign scale_step      = step_q;
  assign scale_line_size = lsize_q;
  assign cfg_err         = err_q;
  assign cfg_sat         = sat_q;
  assign pending         = pend_q;
  assign upd_o           = upd_q;

endmodule
`default_nettype wire

// File: tb/tb_scaler_v_ctrl.sv
`default_nettype none
// ============================================================================
// tb_scaler_v_ctrl : directed self-checking bench for scaler_v_ctrl.
// Rev 1.0
// ============================================================================
module tb_scaler_v_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] cfg_in_height;
  logic [15:0] cfg_out_height;
  logic [15:0] cfg_line_size;
  logic        cfg_valid;
  logic        cfg_ready;
  logic        vs_i;
  logic [15:0] scale_step;
  logic [15:0] scale_line_size;
  logic        cfg_err;
  logic        cfg_sat;
  logic        pending;
  logic        upd_o;

  int n_chk = 0;
  int n_err = 0;

  scaler_v_ctrl #(
    .LINE_STEP        (4096),
    .LINE_SIZE_MAX    (1024),
    .DEFAULT_LINE_SIZE(1024)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .cfg_in_height  (cfg_in_height),
    .cfg_out_height (cfg_out_height),
    .cfg_line_size  (cfg_line_size),
    .cfg_valid      (cfg_valid),
    .cfg_ready      (cfg_ready),
    .vs_i           (vs_i),
    .scale_step     (scale_step),
    .scale_line_size(scale_line_size),
    .cfg_err        (cfg_err),
    .cfg_sat        (cfg_sat),
    .pending        (pending),
    .upd_o          (upd_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Presents one request for one cycle; returns at cycle 1 after accept.
  task automatic req(input logic [15:0] ih, input logic [15:0] oh, input logic [15:0] ls);
    cfg_in_height  = ih;
    cfg_out_height = oh;
    cfg_line_size  = ls;
    cfg_valid      = 1'b1;
    tick(1);
    cfg_valid      = 1'b0;
  endtask

  // Falling vs_i edge with pending staged values; checks the commit.
  task automatic frame_commit(input string tag, input logic [15:0] st, input logic [15:0] ls);
    vs_i = 1'b0;
    tick(1);
    check({tag, "_step"}, 32'(scale_step), 32'(st));
    check({tag, "_line"}, 32'(scale_line_size), 32'(ls));
    check({tag, "_upd"}, 32'(upd_o), 32'd1);
    check({tag, "_pend"}, 32'(pending), 32'd0);
    tick(1);
    check({tag, "_upd_pulse"}, 32'(upd_o), 32'd0);
    vs_i = 1'b1;
    tick(1);
  endtask

  initial begin
    rst = 1'b0;
    vs_i = 1'b1;
    cfg_valid = 1'b0;
    cfg_in_height = 16'd0;
    cfg_out_height = 16'd0;
    cfg_line_size = 16'd0;
    tick(3);
    check("rst_step", 32'(scale_step), 32'd4096);
    check("rst_line", 32'(scale_line_size), 32'd1023);
    check("rst_ready", 32'(cfg_ready), 32'd1);
    check("rst_pend", 32'(pending), 32'd0);
    check("rst_flags", {29'd0, cfg_err, cfg_sat, upd_o}, 32'd0);
    rst = 1'b1;
    tick(1);

    // 1080 -> 720, line 640: step 6144
    req(16'd1080, 16'd720, 16'd640);
    check("a_ready_c1", 32'(cfg_ready), 32'd0);
    tick(28);
    check("a_ready_c29", 32'(cfg_ready), 32'd0);
    check("a_pend_c29", 32'(pending), 32'd0);
    tick(1);
    check("a_pend_c30", 32'(pending), 32'd1);
    check("a_ready_c30", 32'(cfg_ready), 32'd1);
    check("a_step_hold", 32'(scale_step), 32'd4096);
    frame_commit("a", 16'd6144, 16'd639);

    // 720 -> 1080, line 1024: step 2730, waits with no frame edge
    req(16'd720, 16'd1080, 16'd1024);
    tick(29);
    check("b_pend", 32'(pending), 32'd1);
    tick(50);
    check("b_step_hold", 32'(scale_step), 32'd6144);
    check("b_line_hold", 32'(scale_line_size), 32'd639);
    check("b_pend_hold", 32'(pending), 32'd1);
    frame_commit("b", 16'd2730, 16'd1023);

    // rejected requests: out_h = 0, then line = 1025
    req(16'd100, 16'd0, 16'd100);
    check("e0_err", 32'(cfg_err), 32'd1);
    check("e0_ready", 32'(cfg_ready), 32'd1);
    tick(1);
    check("e0_err_pulse", 32'(cfg_err), 32'd0);
    req(16'd100, 16'd50, 16'd1025);
    check("e1_err", 32'(cfg_err), 32'd1);
    check("e1_ready", 32'(cfg_ready), 32'd1);
    tick(1);
    check("e1_err_pulse", 32'(cfg_err), 32'd0);
    check("e_step", 32'(scale_step), 32'd2730);
    check("e_line", 32'(scale_line_size), 32'd1023);
    check("e_pend", 32'(pending), 32'd0);

    // saturation: 65535 -> 1
    req(16'd65535, 16'd1, 16'd100);
    tick(29);
    check("s_sat", 32'(cfg_sat), 32'd1);
    check("s_pend", 32'(pending), 32'd1);
    frame_commit("s", 16'hFFFF, 16'd99);
    check("s_sat_sticky", 32'(cfg_sat), 32'd1);
    req(16'd1080, 16'd720, 16'd640);
    check("s_sat_clr", 32'(cfg_sat), 32'd0);
    tick(29);
    frame_commit("s2", 16'd6144, 16'd639);

    // DONE coinciding with a frame edge while nothing was pending
    req(16'd720, 16'd1080, 16'd1024);
    tick(28);
    vs_i = 1'b0;
    tick(1);
    check("d0_upd", 32'(upd_o), 32'd0);
    check("d0_pend", 32'(pending), 32'd1);
    check("d0_step", 32'(scale_step), 32'd6144);
    vs_i = 1'b1;
    tick(1);
    frame_commit("d0c", 16'd2730, 16'd1023);

    // DONE coinciding with a frame edge while old values were pending
    req(16'd1080, 16'd720, 16'd1024);
    tick(29);
    req(16'd65535, 16'd1, 16'd512);
    tick(28);
    vs_i = 1'b0;
    tick(1);
    check("d1_step", 32'(scale_step), 32'd6144);
    check("d1_line", 32'(scale_line_size), 32'd1023);
    check("d1_upd", 32'(upd_o), 32'd1);
    check("d1_pend", 32'(pending), 32'd1);
    check("d1_sat", 32'(cfg_sat), 32'd1);
    vs_i = 1'b1;
    tick(1);
    frame_commit("d1c", 16'hFFFF, 16'd511);

    // reset in the middle of a division
    req(16'd1080, 16'd720, 16'd640);
    tick(10);
    rst = 1'b0;
    tick(1);
    rst = 1'b1;
    tick(1);
    check("r_pend", 32'(pending), 32'd0);
    check("r_step", 32'(scale_step), 32'd4096);
    check("r_line", 32'(scale_line_size), 32'd1023);
    check("r_ready", 32'(cfg_ready), 32'd1);
    check("r_sat", 32'(cfg_sat), 32'd0);
    tick(30);
    check("r_pend_late", 32'(pending), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
